// File: rtl/uart_tx_pkg.sv
// Shared types and elaboration-time helpers for the UART transmitter.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Clocks per serial bit; truncating division, so the real baud rounds up slightly.
  function automatic int calc_ticks(input int clock_hz, input int baud);
    return clock_hz / baud;
  endfunction

  // Width of the bit-tick counter (0..ticks-1). The floor of 1 keeps degenerate
  // ticks values elaborating; real builds must have ticks >= 2.
  function automatic int calc_cnt_width(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-source side of the transmitter: request/data in, status and serial line out.
interface uart_tx_if;
  logic       Start_i;
  logic [7:0] Data_i;
  logic       Busy_o;
  logic       Done_o;
  logic       Tx_o;

  modport master (output Start_i, output Data_i, input Busy_o, input Done_o, input Tx_o);
  modport slave  (input Start_i, input Data_i, output Busy_o, output Done_o, output Tx_o);
endinterface

// File: rtl/uart_tx_strobe_generator_ticks.sv
// Bit-period timer: counts 0..TICKS-1 while enabled and flags the last cycle of each bit.
module strobe_generator_ticks
  import uart_tx_pkg::*;
#(
  parameter int TICKS = 10
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  output logic Strobe
);

  localparam int            CW   = calc_cnt_width(TICKS);
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);
  localparam logic [CW-1:0] PRE  = CW'(TICKS - 2);

  logic [CW-1:0] count;

  // Count while enabled, park at zero otherwise; Strobe is set one cycle ahead so it
  // is a flop that is high exactly while count == LAST.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count  <= '0;
      Strobe <= 1'b0;
    end else if (Enable) begin
      count  <= (count == LAST) ? '0 : count + 1'b1;
      Strobe <= (count == PRE);
    end else begin
      count  <= '0;
      Strobe <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with Busy/Done handshake that allows zero-gap frame chaining.
//
// state | meaning
// IDLE  | line high, waiting for Start_i
// START | driving the start bit (low) for one bit period
// DATA  | shifting out 8 data bits, LSB first
// STOP  | driving the stop bit (high); Done_o in its last cycle, may chain a new byte
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLOCK_HZ = 1_000_000,
  parameter int BAUD     = 100_000
) (
  input  logic     Clock,
  input  logic     Reset,
  uart_tx_if.slave bus
);

  localparam int TICKS = calc_ticks(CLOCK_HZ, BAUD);

  state_t     state;
  logic [7:0] shift;
  logic [2:0] bit_idx;
  logic       tick;

  // The timer only runs during a frame; it is parked at zero in IDLE so a fresh
  // frame always starts a full bit period, and it wraps to zero on a chained start.
  strobe_generator_ticks #(.TICKS(TICKS)) StrobeGeneratorTicks_inst (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enable (bus.Busy_o),
    .Strobe (tick)
  );

  // Last stop-bit cycle: decode of two flops (state and the registered strobe).
  assign bus.Done_o = (state == STOP) && tick;

  // Frame sequencer with registered Tx/Busy; a request is taken in IDLE or in the Done cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      bus.Tx_o   <= 1'b1;
      bus.Busy_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start_i) begin
            shift      <= bus.Data_i;
            bit_idx    <= '0;
            bus.Tx_o   <= 1'b0;
            bus.Busy_o <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (tick) begin
            bus.Tx_o <= shift[0];
            state    <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              bus.Tx_o <= 1'b1;
              state    <= STOP;
            end else begin
              shift    <= {1'b0, shift[7:1]};
              bus.Tx_o <= shift[1];
              bit_idx  <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (bus.Start_i) begin
              shift    <= bus.Data_i;
              bit_idx  <= '0;
              bus.Tx_o <= 1'b0;
              state    <= START;
            end else begin
              bus.Busy_o <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: begin
          bus.Tx_o   <= 1'b1;
          bus.Busy_o <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a monitor checks each frame.
module tb_uart_tx;

  localparam int TICKS = 10;
  localparam int FRAME = 10 * TICKS;

  logic Clock;
  logic Reset;
  uart_tx_if bus ();

  uart_tx #(.CLOCK_HZ(1_000_000), .BAUD(100_000)) DUT (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int frames_done = 0;
  int busy_low = 0;
  logic [7:0] exp_q[$];

  always @(posedge Clock) cyc++;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  // Monitor: one frame per Busy rise; checks every cycle's Tx against the popped byte.
  initial begin : monitor
    int cnt, bi, tx_err, busy_err, done_cnt, done_pos;
    bit in_frame, have_exp;
    logic [7:0] exp_b, rx;
    logic eb;
    in_frame = 0;
    cnt = 0; tx_err = 0; busy_err = 0; done_cnt = 0; done_pos = -1;
    have_exp = 0; exp_b = 0; rx = 0;
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        in_frame = 0;
      end else begin
        if (!in_frame && bus.Busy_o) begin
          in_frame = 1; cnt = 0; tx_err = 0; busy_err = 0; done_cnt = 0; done_pos = -1; rx = 0;
          if (exp_q.size() == 0) begin
            have_exp = 0; exp_b = 8'h00;
          end else begin
            have_exp = 1; exp_b = exp_q.pop_front();
          end
        end
        if (in_frame) begin
          bi = cnt / TICKS;
          if (bi == 0) eb = 1'b0;
          else if (bi == 9) eb = 1'b1;
          else eb = exp_b[bi-1];
          if (bus.Tx_o !== eb) tx_err++;
          if ((cnt % TICKS) == TICKS / 2 && bi >= 1 && bi <= 8) rx[bi-1] = bus.Tx_o;
          if (bus.Busy_o !== 1'b1) busy_err++;
          if (bus.Done_o === 1'b1) begin done_cnt++; done_pos = cnt; end
          cnt++;
          if (cnt == FRAME) begin
            in_frame = 0;
            frames_done++;
            check("frame_expected", int'(have_exp), 1);
            check("frame_data", int'(rx), int'(exp_b));
            check("frame_tx_cycles_wrong", tx_err, 0);
            check("frame_busy_low_cycles", busy_err, 0);
            check("frame_done_count", done_cnt, 1);
            check("frame_done_pos", done_pos, FRAME - 1);
          end
        end
      end
    end
  end

  // Request from idle; checks the one-clock accept latency.
  task automatic send(input logic [7:0] b);
    bus.Start_i = 1'b1;
    bus.Data_i  = b;
    exp_q.push_back(b);
    @(negedge Clock);
    bus.Start_i = 1'b0;
    check("accept_busy", int'(bus.Busy_o), 1);
    check("accept_tx_low", int'(bus.Tx_o), 0);
  endtask

  // Request in the Done cycle (caller is positioned at that negedge).
  task automatic chain(input logic [7:0] b);
    bus.Start_i = 1'b1;
    bus.Data_i  = b;
    exp_q.push_back(b);
    @(negedge Clock);
    bus.Start_i = 1'b0;
    if (bus.Busy_o !== 1'b1) busy_low++;
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge Clock);
      if (bus.Busy_o !== 1'b1) busy_low++;
      if (bus.Done_o === 1'b1) begin
        t = cyc;
        return;
      end
    end
    tests++; fails++;
    $display("FAIL wait_done: no Done_o within %0d cycles, expected a pulse", 3 * FRAME);
  endtask

  initial begin : stimulus
    int t, n, dn, dpos, gap;
    int tdone[5];
    logic [7:0] hello[5];
    hello[0] = 8'h48; hello[1] = 8'h65; hello[2] = 8'h6C; hello[3] = 8'h6C; hello[4] = 8'h6F;

    // reset / idle
    Reset = 1'b0;
    bus.Start_i = 1'b0;
    bus.Data_i  = 8'h00;
    repeat (3) @(negedge Clock);
    check("reset_tx", int'(bus.Tx_o), 1);
    check("reset_busy", int'(bus.Busy_o), 0);
    check("reset_done", int'(bus.Done_o), 0);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    check("idle_tx", int'(bus.Tx_o), 1);
    check("idle_busy", int'(bus.Busy_o), 0);
    check("ticks_param", DUT.StrobeGeneratorTicks_inst.TICKS, 10);

    // single byte 'H': busy length and done position
    send(8'h48);
    n = 1; dn = 0; dpos = -1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge Clock);
      if (bus.Busy_o !== 1'b1) break;
      n++;
      if (bus.Done_o === 1'b1) begin dn++; dpos = n; end
    end
    check("single_busy_cycles", n, FRAME);
    check("single_done_count", dn, 1);
    check("single_done_cycle", dpos, FRAME);
    repeat (5) @(negedge Clock);

    // back-to-back "Hello"
    busy_low = 0;
    send(hello[0]);
    for (int k = 0; k < 5; k++) begin
      wait_done(t);
      tdone[k] = t;
      if (k < 4) chain(hello[k+1]);
    end
    check("hello_busy_gaps", busy_low, 0);
    for (int k = 1; k < 5; k++) begin
      gap = tdone[k] - tdone[k-1];
      check("hello_done_spacing", gap, FRAME);
    end
    @(negedge Clock);
    check("hello_busy_after", int'(bus.Busy_o), 0);
    repeat (5) @(negedge Clock);

    // start ignored while busy
    send(8'h00);
    repeat (34) @(negedge Clock);
    bus.Start_i = 1'b1;
    bus.Data_i  = 8'hFF;
    @(negedge Clock);
    bus.Start_i = 1'b0;
    wait_done(t);
    n = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge Clock);
      if (bus.Busy_o === 1'b1) n++;
    end
    check("ignored_no_extra_busy", n, 0);

    // reset during data bit 3
    send(8'hA5);
    repeat (44) @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    check("midreset_tx", int'(bus.Tx_o), 1);
    check("midreset_busy", int'(bus.Busy_o), 0);
    check("midreset_done", int'(bus.Done_o), 0);
    @(negedge Clock);
    #1 Reset = 1'b1;
    repeat (3) @(negedge Clock);
    check("postreset_busy", int'(bus.Busy_o), 0);
    send(8'h3C);
    wait_done(t);
    repeat (3) @(negedge Clock);

    // Data_i changed right after accept
    send(8'hC3);
    bus.Data_i = 8'h5A;
    wait_done(t);
    repeat (10) @(negedge Clock);

    check("scoreboard_empty", exp_q.size(), 0);
    check("frames_completed", frames_done, 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
